// File: rtl/bcd_timekeeper.sv
// -----------------------------------------------------------------------------
// bcd_timekeeper
//
// Six-digit BCD time-of-day counter. Time is kept internally in 24 h form.
// The hour display can be shown in 24 h form or in 12 h form with an AM/PM
// flag. The block supports run/hold, per-digit loading with validation and an
// error pulse, and a one-cycle pulse when the day rolls over.
//
// Parameters
//   RST_HOUR   reset hour, packed BCD {tens,units}, 24 h form (00-23)
//   RST_MIN    reset minute, packed BCD (00-59)
//   RST_SEC    reset second, packed BCD (00-59)
//   START_RUN  1: count out of reset when run=1
//              0: stay held until the first successful load
//
// Ports
//   CLK_1Hz             one tick per second; all state changes on its rising edge
//   reset               synchronous, active-low
//   run                 1 = advance one second per clock, 0 = hold
//   mode12              1 = 12 h hour display, 0 = 24 h hour display
//   load                write num into the digit chosen by sel
//   sel[2:0]            0 sec units .. 5 hour tens; 6 and 7 are rejected
//   num[3:0]            BCD digit to load
//   second_d/second_g   seconds units/tens (BCD)
//   minute_d/minute_g   minutes units/tens (BCD)
//   hour_d/hour_g       displayed hour units/tens (BCD), format set by mode12
//   pm                  PM flag in 12 h mode, 0 in 24 h mode
//   day_tick            one-cycle pulse on 23:59:59 -> 00:00:00
//   load_err            one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module bcd_timekeeper #(
    parameter logic [7:0] RST_HOUR  = 8'h12,
    parameter logic [7:0] RST_MIN   = 8'h00,
    parameter logic [7:0] RST_SEC   = 8'h00,
    parameter bit         START_RUN = 1'b1
) (
    input  logic       CLK_1Hz,
    input  logic       reset,
    input  logic       run,
    input  logic       mode12,
    input  logic       load,
    input  logic [2:0] sel,
    input  logic [3:0] num,
    output logic [3:0] second_d,
    output logic [3:0] second_g,
    output logic [3:0] minute_d,
    output logic [3:0] minute_g,
    output logic [3:0] hour_d,
    output logic [3:0] hour_g,
    output logic       pm,
    output logic       day_tick,
    output logic       load_err
);

    // Digit order matches sel: [0] sec units ... [5] hour tens.
    localparam logic [5:0][3:0] RST_DIGITS = {RST_HOUR, RST_MIN, RST_SEC};

    // Wrap value for the four seconds/minutes digits ([0] sec units .. [3] min tens).
    localparam logic [3:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [5:0][3:0] digit_reg;
    logic [5:0][3:0] digit_next;
    logic            enable_reg;
    logic            enable_next;
    logic            day_tick_reg;
    logic            day_tick_next;
    logic            load_err_reg;
    logic            load_err_next;
    logic [3:0]      hour_d_disp_reg;
    logic [3:0]      hour_d_disp_next;
    logic [3:0]      hour_g_disp_reg;
    logic [3:0]      hour_g_disp_next;
    logic            pm_reg;
    logic            pm_next;

    // ------------------------------------------------------------------
    // Counting path: ripple carry through the minutes/seconds digits
    // ------------------------------------------------------------------
    logic [4:0] carry;
    logic [3:0] at_max;
    logic [3:0] digit_cnt [4];

    assign carry[0] = run & enable_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ms_digit
            assign at_max[gi]    = (digit_reg[gi] == DIGIT_MAX[gi]);
            assign carry[gi + 1] = carry[gi] & at_max[gi];
            assign digit_cnt[gi] = !carry[gi] ? digit_reg[gi] :
                                   at_max[gi] ? 4'd0 :
                                                digit_reg[gi] + 4'd1;
        end
    endgenerate

    // Hours do not wrap digit by digit: units wrap at 9 normally but the pair
    // wraps from 23 to 00, which is also the day rollover.
    logic       hour_wrap;
    logic [3:0] hour_d_cnt;
    logic [3:0] hour_g_cnt;

    assign hour_wrap = carry[4] && (digit_reg[5] == 4'd2) && (digit_reg[4] == 4'd3);

    always_comb begin
        hour_d_cnt = digit_reg[4];
        hour_g_cnt = digit_reg[5];
        if (carry[4]) begin
            if (hour_wrap) begin
                hour_d_cnt = 4'd0;
                hour_g_cnt = 4'd0;
            end else if (digit_reg[4] == 4'd9) begin
                hour_d_cnt = 4'd0;
                hour_g_cnt = digit_reg[5] + 4'd1;
            end else begin
                hour_d_cnt = digit_reg[4] + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load validation against the current 24 h value. The hour rules keep
    // the hour pair within 00-23 whichever digit is written.
    // ------------------------------------------------------------------
    logic load_ok;

    always_comb begin
        load_ok = 1'b0;
        case (sel)
            3'd0, 3'd2: load_ok = (num <= 4'd9);
            3'd1, 3'd3: load_ok = (num <= 4'd5);
            3'd4:       load_ok = (num <= 4'd9) &&
                                  ((digit_reg[5] != 4'd2) || (num <= 4'd3));
            3'd5:       load_ok = (num <= 4'd2) &&
                                  ((digit_reg[4] <= 4'd3) || (num < 4'd2));
            default:    load_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state selection: reset > load > count
    // ------------------------------------------------------------------
    always_comb begin
        digit_next    = digit_reg;
        enable_next   = enable_reg;
        day_tick_next = 1'b0;
        load_err_next = 1'b0;

        if (!reset) begin
            digit_next  = RST_DIGITS;
            enable_next = START_RUN;
        end else if (load) begin
            if (load_ok) begin
                digit_next[sel] = num;
                enable_next     = 1'b1;
            end else begin
                load_err_next = 1'b1;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                digit_next[i] = digit_cnt[i];
            end
            digit_next[4] = hour_d_cnt;
            digit_next[5] = hour_g_cnt;
            day_tick_next = hour_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Hour display mapping, computed from the post-edge time so the
    // registered display carries no extra cycle of latency.
    // ------------------------------------------------------------------
    logic [4:0] hour_bin;
    logic [4:0] disp_bin;

    assign hour_bin = ({1'b0, digit_next[5]} * 5'd10) + {1'b0, digit_next[4]};

    always_comb begin
        disp_bin = hour_bin;
        pm_next  = 1'b0;
        if (mode12) begin
            if (hour_bin == 5'd0) begin
                disp_bin = 5'd12;
            end else if (hour_bin >= 5'd12) begin
                pm_next = 1'b1;
                if (hour_bin > 5'd12) begin
                    disp_bin = hour_bin - 5'd12;
                end
            end
        end
    end

    // Binary back to BCD; display hours never exceed 23.
    always_comb begin
        hour_g_disp_next = 4'd0;
        hour_d_disp_next = disp_bin[3:0];
        if (disp_bin >= 5'd20) begin
            hour_g_disp_next = 4'd2;
            hour_d_disp_next = 4'(disp_bin - 5'd20);
        end else if (disp_bin >= 5'd10) begin
            hour_g_disp_next = 4'd1;
            hour_d_disp_next = 4'(disp_bin - 5'd10);
        end
    end

    // ------------------------------------------------------------------
    // Registers (reset is folded into the next-state logic above)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_1Hz) begin
        digit_reg       <= digit_next;
        enable_reg      <= enable_next;
        day_tick_reg    <= day_tick_next;
        load_err_reg    <= load_err_next;
        hour_d_disp_reg <= hour_d_disp_next;
        hour_g_disp_reg <= hour_g_disp_next;
        pm_reg          <= pm_next;
    end

    assign second_d = digit_reg[0];
    assign second_g = digit_reg[1];
    assign minute_d = digit_reg[2];
    assign minute_g = digit_reg[3];
    assign hour_d   = hour_d_disp_reg;
    assign hour_g   = hour_g_disp_reg;
    assign pm       = pm_reg;
    assign day_tick = day_tick_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// -----------------------------------------------------------------------------
// tb_bcd_timekeeper
//
// Two instances share one stimulus stream: u_dut_run (reset 12:00:00, counts
// out of reset) and u_dut_hold (reset 09:30:00, held until the first valid
// load). Every edge both are compared with a reference model that keeps the
// time as seconds-of-day. A table of directed vectors additionally carries
// hand-computed expected displays for u_dut_run.
// -----------------------------------------------------------------------------
module tb_bcd_timekeeper;

    logic       CLK_1Hz = 1'b0;
    logic       reset;
    logic       run;
    logic       mode12;
    logic       load;
    logic [2:0] sel;
    logic [3:0] num;

    always #5 CLK_1Hz = ~CLK_1Hz;

    logic [3:0] a_sd, a_sg, a_md, a_mg, a_hd, a_hg;
    logic       a_pm, a_day, a_err;
    logic [3:0] b_sd, b_sg, b_md, b_mg, b_hd, b_hg;
    logic       b_pm, b_day, b_err;

    bcd_timekeeper #(
        .RST_HOUR (8'h12),
        .RST_MIN  (8'h00),
        .RST_SEC  (8'h00),
        .START_RUN(1'b1)
    ) u_dut_run (
        .CLK_1Hz (CLK_1Hz),
        .reset   (reset),
        .run     (run),
        .mode12  (mode12),
        .load    (load),
        .sel     (sel),
        .num     (num),
        .second_d(a_sd),
        .second_g(a_sg),
        .minute_d(a_md),
        .minute_g(a_mg),
        .hour_d  (a_hd),
        .hour_g  (a_hg),
        .pm      (a_pm),
        .day_tick(a_day),
        .load_err(a_err)
    );

    bcd_timekeeper #(
        .RST_HOUR (8'h09),
        .RST_MIN  (8'h30),
        .RST_SEC  (8'h00),
        .START_RUN(1'b0)
    ) u_dut_hold (
        .CLK_1Hz (CLK_1Hz),
        .reset   (reset),
        .run     (run),
        .mode12  (mode12),
        .load    (load),
        .sel     (sel),
        .num     (num),
        .second_d(b_sd),
        .second_g(b_sg),
        .minute_d(b_md),
        .minute_g(b_mg),
        .hour_d  (b_hd),
        .hour_g  (b_hg),
        .pm      (b_pm),
        .day_tick(b_day),
        .load_err(b_err)
    );

    // {hour_g,hour_d,minute_g,minute_d,second_g,second_d,pm,day_tick,load_err}
    logic [26:0] obs_run;
    logic [26:0] obs_hold;
    assign obs_run  = {a_hg, a_hd, a_mg, a_md, a_sg, a_sd, a_pm, a_day, a_err};
    assign obs_hold = {b_hg, b_hd, b_mg, b_md, b_sg, b_sd, b_pm, b_day, b_err};

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    // ------------------------------------------------------------------
    // Reference model: time as seconds since midnight
    // ------------------------------------------------------------------
    int rst_t     [2] = '{43200, 34200};   // 12:00:00, 09:30:00
    bit start_run [2] = '{1'b1, 1'b0};
    int mt   [2];
    bit men  [2];
    bit mday [2];
    bit merr [2];
    bit mm12;

    // Replace one decimal digit of the time; accepted only if the digit is
    // decimal and the resulting field stays a legal second/minute/hour.
    function automatic bit try_load(input int t, input logic [2:0] s,
                                    input logic [3:0] n, output int t_new);
        int h, m, sc, v, nn;
        h     = t / 3600;
        m     = (t / 60) % 60;
        sc    = t % 60;
        nn    = int'(n);
        t_new = t;
        if (nn > 9) return 1'b0;
        case (s)
            3'd0: begin v = (sc / 10) * 10 + nn; if (v < 60) begin t_new = h*3600 + m*60 + v; return 1'b1; end end
            3'd1: begin v = nn * 10 + sc % 10;   if (v < 60) begin t_new = h*3600 + m*60 + v; return 1'b1; end end
            3'd2: begin v = (m / 10) * 10 + nn;  if (v < 60) begin t_new = h*3600 + v*60 + sc; return 1'b1; end end
            3'd3: begin v = nn * 10 + m % 10;    if (v < 60) begin t_new = h*3600 + v*60 + sc; return 1'b1; end end
            3'd4: begin v = (h / 10) * 10 + nn;  if (v < 24) begin t_new = v*3600 + m*60 + sc; return 1'b1; end end
            3'd5: begin v = nn * 10 + h % 10;    if (v < 24) begin t_new = v*3600 + m*60 + sc; return 1'b1; end end
            default: ;
        endcase
        return 1'b0;
    endfunction

    task automatic model_edge();
        int tn;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                mt[k]   = rst_t[k];
                men[k]  = start_run[k];
                mday[k] = 1'b0;
                merr[k] = 1'b0;
            end else if (load) begin
                mday[k] = 1'b0;
                if (try_load(mt[k], sel, num, tn)) begin
                    mt[k]   = tn;
                    men[k]  = 1'b1;
                    merr[k] = 1'b0;
                end else begin
                    merr[k] = 1'b1;
                end
            end else begin
                merr[k] = 1'b0;
                mday[k] = 1'b0;
                if (run && men[k]) begin
                    mt[k]   = (mt[k] + 1) % 86400;
                    mday[k] = (mt[k] == 0);
                end
            end
        end
        mm12 = mode12;
    endtask

    function automatic logic [26:0] expected(input int k);
        int  h, dh, m, sc;
        bit  p;
        h  = mt[k] / 3600;
        m  = (mt[k] / 60) % 60;
        sc = mt[k] % 60;
        dh = h;
        p  = 1'b0;
        if (mm12) begin
            dh = (h % 12 == 0) ? 12 : h % 12;
            p  = (h >= 12);
        end
        return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10),
                4'(sc / 10), 4'(sc % 10), p, mday[k], merr[k]};
    endfunction

    task automatic check_obs(input string name, input logic [26:0] got,
                             input logic [26:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d got=%h expected=%h", name, step_no, got, exp);
        end
    endtask

    // Drive one cycle, clock it, update the model, compare both instances.
    task automatic step(input logic r, input logic ru, input logic m,
                        input logic l, input logic [2:0] s, input logic [3:0] n);
        reset  = r;
        run    = ru;
        mode12 = m;
        load   = l;
        sel    = s;
        num    = n;
        @(posedge CLK_1Hz);
        model_edge();
        #1;
        step_no++;
        $display("step %0d rst=%0b run=%0b m12=%0b ld=%0b sel=%0d num=%h | run_dut=%h hold_dut=%h",
                 step_no, r, ru, m, l, s, n, obs_run, obs_hold);
        check_obs("model_run", obs_run, expected(0));
        check_obs("model_hold", obs_hold, expected(1));
    endtask

    // ------------------------------------------------------------------
    // Directed vectors for u_dut_run
    // ------------------------------------------------------------------
    typedef struct {
        logic        r;
        logic        ru;
        logic        m12;
        logic        l;
        logic [2:0]  s;
        logic [3:0]  n;
        logic [23:0] hms;
        logic        p;
        logic        d;
        logic        e;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic ru, input logic m12,
                                input logic l, input logic [2:0] s, input logic [3:0] n,
                                input logic [23:0] hms, input logic p,
                                input logic d, input logic e);
        vec_t v;
        v.r = r; v.ru = ru; v.m12 = m12; v.l = l; v.s = s; v.n = n;
        v.hms = hms; v.p = p; v.d = d; v.e = e;
        return v;
    endfunction

    initial begin
        reset = 1'b0; run = 1'b0; mode12 = 1'b0; load = 1'b0; sel = 3'd0; num = 4'd0;

        //                     r  ru m12 l  sel  num    display    pm day err
        vecs.push_back(mk(0, 1, 0, 0, 3'd0, 4'h0, 24'h120000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3'd0, 4'h0, 24'h120000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3'd0, 4'h0, 24'h120001, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3'd0, 4'h0, 24'h120002, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 3'd0, 4'h0, 24'h120003, 1, 0, 0));
        // load 23:59:58
        vecs.push_back(mk(1, 0, 0, 1, 3'd5, 4'h2, 24'h220003, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd4, 4'h3, 24'h230003, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd3, 4'h5, 24'h235003, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd2, 4'h9, 24'h235903, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd1, 4'h5, 24'h235953, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd0, 4'h8, 24'h235958, 0, 0, 0));
        // day rollover
        vecs.push_back(mk(1, 1, 0, 0, 3'd0, 4'h0, 24'h235959, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3'd0, 4'h0, 24'h000000, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3'd0, 4'h0, 24'h000001, 0, 0, 0));
        // 12 h mapping: 00:xx -> 12 AM, 10 -> 10 AM, 13 -> 01 PM
        vecs.push_back(mk(1, 0, 1, 0, 3'd0, 4'h0, 24'h120001, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 3'd3, 4'h3, 24'h123001, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 3'd5, 4'h1, 24'h103001, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 3'd4, 4'h3, 24'h013001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 3'd3, 4'h0, 24'h010001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 3'd2, 4'h5, 24'h010501, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 3'd0, 4'h0, 24'h010500, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'd0, 4'h0, 24'h130500, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 3'd0, 4'h0, 24'h010500, 1, 0, 0));
        // rejected loads
        vecs.push_back(mk(1, 0, 1, 1, 3'd1, 4'h6, 24'h010500, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 3'd5, 4'h2, 24'h230500, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd4, 4'h5, 24'h230500, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 3'd6, 4'h1, 24'h230500, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 3'd0, 4'hA, 24'h230500, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 3'd7, 4'h0, 24'h230500, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 3'd0, 4'h0, 24'h230500, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd5, 4'h1, 24'h130500, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd4, 4'h4, 24'h140500, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd5, 4'h2, 24'h140500, 0, 0, 1));
        // load while running at 10:20:59: no carry on the load edge
        vecs.push_back(mk(1, 0, 0, 1, 3'd4, 4'h0, 24'h100500, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd3, 4'h2, 24'h102500, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd2, 4'h0, 24'h102000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd1, 4'h5, 24'h102050, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd0, 4'h9, 24'h102059, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 3'd3, 4'h4, 24'h104059, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3'd0, 4'h0, 24'h104100, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3'd0, 4'h0, 24'h104101, 0, 0, 0));
        // load 07:45:12, then reset during a load
        vecs.push_back(mk(1, 0, 0, 1, 3'd5, 4'h0, 24'h004101, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd4, 4'h7, 24'h074101, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd2, 4'h5, 24'h074501, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd1, 4'h1, 24'h074511, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3'd0, 4'h2, 24'h074512, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 3'd4, 4'h9, 24'h120000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 3'd6, 4'h0, 24'h120000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3'd0, 4'h0, 24'h120000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3'd0, 4'h0, 24'h120001, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].ru, vecs[i].m12, vecs[i].l, vecs[i].s, vecs[i].n);
            check_obs("table_run", obs_run,
                      {vecs[i].hms, vecs[i].p, vecs[i].d, vecs[i].e});
        end

        // START_RUN=0 instance: held after reset until the first valid load.
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
            check_obs("hold_idle", obs_hold, {24'h093000, 3'b000});
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 4'h5);
        check_obs("hold_load", obs_hold, {24'h093005, 3'b000});
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
        check_obs("hold_start", obs_hold, {24'h093006, 3'b000});
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
        check_obs("hold_freeze", obs_hold, {24'h093006, 3'b000});
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
        check_obs("hold_resume", obs_hold, {24'h093007, 3'b000});

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0),
                 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_timekeeper.md
Name: bcd_timekeeper

Overview:
- Parametrised successor to the team's six-digit BCD time-of-day counter. Clocked by CLK_1Hz.
- Keeps time internally in 24 h format; the hour display is selectable between 24 h and 12 h with an AM/PM flag.
- Adds run/hold control, validated per-digit loading with an error pulse, and a day-rollover pulse for a downstream calendar/alarm block.
- Sits between the set-key decoder and the seven-segment display multiplexer.

Parameters:
- RST_HOUR, 8'h12, reset hour, packed BCD {tens,units}, 24 h format; must be valid 00–23 (not checked).
- RST_MIN, 8'h00, reset minute, packed BCD; valid 00–59.
- RST_SEC, 8'h00, reset second, packed BCD; valid 00–59.
- START_RUN, 1, 1 = counter advances out of reset when run=1; 0 = counter stays held until the first successful load.

Ports:
- CLK_1Hz  input  1  one tick per second; all state changes on the rising edge.
- reset  input  1  synchronous, active-low.
- run  input  1  1 = advance one second per clock; 0 = hold.
- mode12  input  1  1 = 12 h display, 0 = 24 h display.
- load  input  1  write num into the digit chosen by sel this cycle.
- sel  input  3  0 sec units, 1 sec tens, 2 min units, 3 min tens, 4 hour units, 5 hour tens; 6 and 7 are illegal.
- num  input  4  BCD digit to load.
- second_d, second_g, minute_d, minute_g  output  4 each  seconds/minutes units (_d) and tens (_g), BCD.
- hour_d, hour_g  output  4 each  displayed hour units/tens, BCD, in the format set by mode12.
- pm  output  1  12 h mode: 1 = PM. Forced to 0 in 24 h mode.
- day_tick  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (reset=0 at an edge):
  - Internal time is set to RST_HOUR:RST_MIN:RST_SEC.
  - day_tick=0, load_err=0.
  - Internal enable flag = START_RUN.
  - Display outputs are updated from the reset value through the normal mapping on the same edge.
  - Reset overrides load and run.
- Priority per edge: reset > load > count.
  - In a load cycle no digit advances, whatever the value of run.
- Count (run=1, enable flag=1, no load):
  - Time advances by exactly 1 s per edge.
  - sec_d wraps 9->0 and carries into sec_g; sec_g wraps 5->0 and carries into minutes.
  - Minutes behave the same way and carry into hours.
  - Hours wrap 23->00; hour_g increments on hour_d 9->0.
  - On 23:59:59->00:00:00, day_tick=1 for that cycle only.
- Hold (run=0 or enable flag=0): all digits are held, day_tick=0.
- Load validation, against the internal 24 h value:
  - sel 0/2: num<=9. sel 1/3: num<=5.
  - sel 4: num<=9, and num<=3 if current hour_g==2.
  - sel 5: num<=2, and num<2 if current hour_d>3.
  - sel 6/7: always invalid. num>9: always invalid.
  - Valid load: digit written, enable flag set to 1, load_err=0.
  - Invalid load: no state change, load_err=1 for one cycle.
  - Hour loads always use the 24 h representation, regardless of mode12.
- Display mapping:
  - Outputs are registered and reflect the post-edge internal time on the same edge (zero added latency).
  - 24 h mode: hour outputs = internal hour, pm=0.
  - 12 h mode:
    - H=0 -> 12, pm=0.
    - 1–11 -> H, pm=0.
    - 12 -> 12, pm=1.
    - 13–23 -> H-12, pm=1.
  - BCD arithmetic is done on 5-bit binary hour with conversion back to BCD; no digit ever exceeds 9.
- A change of mode12 takes effect on the next edge and never alters internal time.
- Seconds and minutes outputs are the internal registers directly.

Test Plan:
- Reset defaults, run=1, 3 edges -> 12:00:00 then 12:00:03. In 12 h mode the display reads 12:00:03 with pm=1.
- Load 23:59:58 through six valid loads, then run 2 edges -> 23:59:59, then 00:00:00 with day_tick=1 for exactly that cycle; next edge 00:00:01 with day_tick=0.
- mode12=1 with internal 00:30:00 -> hour 12, pm=0. With internal 13:05:00 -> hour 01, pm=1. Toggling mode12 leaves minutes and seconds unchanged.
- Invalid loads:
  - sel=1, num=6 -> load_err pulse, sec_g unchanged.
  - hour_g=2, sel=4, num=5 -> load_err.
  - sel=6 -> load_err.
  - num=4'hA -> load_err.
- load asserted with run=1 at 10:20:59 -> the loaded digit is written, no carry occurs, and the count resumes on the next edge.
- START_RUN=0: after reset the counter stays at the reset time for 5 edges; the first valid load starts counting. run=0 mid-count freezes time, run=1 resumes.
- Assert reset during a load at 07:45:12 -> outputs equal the reset time and load_err=0.
